fpu_q_mac: RTL and testbench

Sequential fixed-point arithmetic unit sitting directly downstream of the FPU input multiplexers. It consumes two signed 64-bit Q32.32 operands, each already selected and converted by an input mux. It performs multiply, multiply-accumulate, saturating add, or accumulator clear, and returns a saturated Q32.32 result over a valid/ready handshake. Multiplication is iterative (one partial product per cycle) to keep area small.

---
 rtl/fpu_pkg.sv | 32 +++
 rtl/fpu_q_mac_if.sv | 24 ++
 rtl/q_sat_add.sv | 19 +
 rtl/fpu_q_mac.sv | 134 +++++++++++++
 tb/tb_fpu_q_mac.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/fpu_pkg.sv
// Shared definitions for the fixed-point Q32.32 arithmetic unit.
// Holds op encodings, Q-format constants, FSM states and the debug view.
package fpu_pkg;

  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_MAC = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  localparam logic [63:0] Q_ONE = 64'h0000_0001_0000_0000;
  localparam logic [63:0] Q_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] Q_MIN = 64'h8000_0000_0000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_FIN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  typedef struct packed {
    state_t     state;
    logic [5:0] cnt;
    logic       inexact;
  } dbg_t;

  // Unsigned magnitude; the most negative value maps exactly to 2^63.
  function automatic logic [63:0] abs64(input logic [63:0] v);
    return v[63] ? (~v + 64'd1) : v;
  endfunction

endpackage

// File: rtl/fpu_q_mac_if.sv
// Request/response bundle between the FPU input muxes and the Q32.32 MAC unit.
// Both directions use valid/ready: a transfer happens on a rising edge where valid && ready.
interface fpu_q_mac_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [63:0] a_data;
  logic [63:0] b_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_sat;
  logic [63:0] acc_data;

  modport master (
    output in_valid, op, a_data, b_data, out_ready,
    input  in_ready, out_valid, out_data, out_sat, acc_data
  );

  modport slave (
    input  in_valid, op, a_data, b_data, out_ready,
    output in_ready, out_valid, out_data, out_sat, acc_data
  );
endinterface

// File: rtl/q_sat_add.sv
// Combinational signed 64-bit adder that clamps to Q_MAX/Q_MIN on overflow.
module q_sat_add
  import fpu_pkg::*;
(
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] y,
  output logic        ovf
);

  logic [63:0] sum;

  always_comb begin
    sum = a + b;
    ovf = (a[63] == b[63]) && (sum[63] != a[63]);
    y   = ovf ? (a[63] ? Q_MIN : Q_MAX) : sum;
  end

endmodule

// File: rtl/fpu_q_mac.sv
// Sequential Q32.32 MUL / MAC / saturating ADD / CLR unit.
// The multiplier is shift-and-add on operand magnitudes, one bit of |B| per cycle.
module fpu_q_mac
  import fpu_pkg::*;
#(
  parameter int Q_FRAC = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  fpu_q_mac_if.slave    bus,
  output dbg_t          dbg
);

  state_t       state, state_nx;
  logic [1:0]   op_q;
  logic [63:0]  mag_a, mag_b;
  logic         neg_q;
  logic [5:0]   cnt;
  logic [127:0] prod;
  logic [127:0] partial;
  logic [63:0]  res_q, acc_q;
  logic         sat_q;

  logic [63:0]  q_mag, fin_val;
  logic         hi_ovf, fin_sat;
  logic [63:0]  add_a, add_b, add_y;
  logic         add_ovf;

  // Rounding is truncation of the magnitude, so negative results round toward zero.
  always_comb begin
    q_mag   = prod[Q_FRAC +: 64];
    hi_ovf  = |prod[127:Q_FRAC+64];
    fin_sat = 1'b0;
    fin_val = q_mag;
    if (!neg_q) begin
      if (hi_ovf || q_mag[63]) begin
        fin_sat = 1'b1;
        fin_val = Q_MAX;
      end
    end else if (hi_ovf || (q_mag[63] && (|q_mag[62:0]))) begin
      fin_sat = 1'b1;
      fin_val = Q_MIN;
    end else begin
      fin_val = 64'd0 - q_mag;
    end
  end

  // One adder serves ADD at acceptance and the MAC accumulate in FIN.
  assign add_a = (state == S_IDLE) ? bus.a_data : acc_q;
  assign add_b = (state == S_IDLE) ? bus.b_data : fin_val;

  q_sat_add u_add (
    .a   (add_a),
    .b   (add_b),
    .y   (add_y),
    .ovf (add_ovf)
  );

  assign partial = {64'd0, mag_a} << cnt;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (bus.in_valid) begin
        state_nx = (bus.op == OP_MUL || bus.op == OP_MAC) ? S_MUL : S_DONE;
      end
      S_MUL:  if (cnt == 6'd63) state_nx = S_FIN;
      S_FIN:  state_nx = S_DONE;
      S_DONE: if (bus.out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      op_q  <= OP_MUL;
      mag_a <= '0;
      mag_b <= '0;
      neg_q <= 1'b0;
      cnt   <= '0;
      prod  <= '0;
      res_q <= '0;
      acc_q <= '0;
      sat_q <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: if (bus.in_valid) begin
          op_q  <= bus.op;
          mag_a <= abs64(bus.a_data);
          mag_b <= abs64(bus.b_data);
          neg_q <= bus.a_data[63] ^ bus.b_data[63];
          cnt   <= '0;
          prod  <= '0;
          if (bus.op == OP_ADD) begin
            res_q <= add_y;
            sat_q <= add_ovf;
          end else if (bus.op == OP_CLR) begin
            res_q <= '0;
            sat_q <= 1'b0;
            acc_q <= '0;
          end
        end
        S_MUL: begin
          if (mag_b[cnt]) prod <= prod + partial;
          cnt <= cnt + 6'd1;
        end
        S_FIN: begin
          if (op_q == OP_MAC) begin
            res_q <= add_y;
            sat_q <= fin_sat | add_ovf;
            acc_q <= add_y;
          end else begin
            res_q <= fin_val;
            sat_q <= fin_sat;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.out_data  = res_q;
  assign bus.out_sat   = sat_q;
  assign bus.acc_data  = acc_q;

  assign dbg.state   = state;
  assign dbg.cnt     = cnt;
  assign dbg.inexact = |prod[Q_FRAC-1:0];

endmodule

// File: tb/tb_fpu_q_mac.sv
// Directed bench for fpu_q_mac: hand-computed Q32.32 results checked through one task.
module tb_fpu_q_mac;
  import fpu_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  dbg_t dbg;

  fpu_q_mac_if bus ();

  fpu_q_mac #(.Q_FRAC(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .dbg     (dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [63:0] exp_q[$];

  localparam logic [63:0] V_1P5  = 64'h0000_0001_8000_0000;
  localparam logic [63:0] V_2P0  = 64'h0000_0002_0000_0000;
  localparam logic [63:0] V_M2P0 = 64'hFFFF_FFFE_0000_0000;
  localparam logic [63:0] V_M1P0 = 64'hFFFF_FFFF_0000_0000;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic issue(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    int w = 0;
    while (!bus.in_ready && w < 200) begin
      tick();
      w++;
    end
    check("issue_ready", {63'd0, bus.in_ready}, 64'd1);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.a_data   = a;
    bus.b_data   = b;
    tick();
    bus.in_valid = 1'b0;
    bus.op       = 2'($urandom_range(0, 3));
    bus.a_data   = {$urandom, $urandom};
    bus.b_data   = {$urandom, $urandom};
  endtask

  task automatic wait_result(input string tag, input int exp_lat, input logic exp_sat);
    int lat = 0;
    while (!bus.out_valid && lat < 200) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_data"}, bus.out_data, exp_q.pop_front());
    check({tag, "_sat"}, {63'd0, bus.out_sat}, {63'd0, exp_sat});
  endtask

  task automatic consume;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp_data, input logic exp_sat);
    exp_q.push_back(exp_data);
    issue(op, a, b);
    wait_result(tag, (op == OP_MUL || op == OP_MAC) ? 65 : 0, exp_sat);
    consume();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.op        = OP_MUL;
    bus.a_data    = '0;
    bus.b_data    = '0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_out_data", bus.out_data, 64'd0);
    check("rst_out_sat", {63'd0, bus.out_sat}, 64'd0);
    check("rst_acc", bus.acc_data, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    run_op("mul_neg", OP_MUL, V_1P5, V_M2P0, 64'hFFFF_FFFD_0000_0000, 1'b0);
    run_op("mul_ovf_max", OP_MUL, Q_MAX, V_2P0, Q_MAX, 1'b1);
    run_op("mul_ovf_min", OP_MUL, Q_MIN, V_2P0, Q_MIN, 1'b1);
    run_op("trunc_pos", OP_MUL, 64'h1, 64'h8000_0000, 64'd0, 1'b0);
    run_op("trunc_neg", OP_MUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000, 64'd0, 1'b0);

    run_op("clr", OP_CLR, V_1P5, V_2P0, 64'd0, 1'b0);
    check("clr_acc", bus.acc_data, 64'd0);
    run_op("mac1", OP_MAC, V_1P5, V_2P0, 64'h0000_0003_0000_0000, 1'b0);
    check("mac1_acc", bus.acc_data, 64'h0000_0003_0000_0000);
    run_op("mac2", OP_MAC, V_1P5, V_2P0, 64'h0000_0006_0000_0000, 1'b0);
    check("mac2_acc", bus.acc_data, 64'h0000_0006_0000_0000);
    run_op("mac3", OP_MAC, V_1P5, V_2P0, 64'h0000_0009_0000_0000, 1'b0);
    check("mac3_acc", bus.acc_data, 64'h0000_0009_0000_0000);

    // ADD saturates and is held in DONE while a CLR request is refused
    exp_q.push_back(Q_MAX);
    issue(OP_ADD, Q_MAX, Q_ONE);
    wait_result("add_sat", 0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.op       = OP_CLR;
      tick();
      check("bp_out_valid", {63'd0, bus.out_valid}, 64'd1);
      check("bp_out_data", bus.out_data, Q_MAX);
      check("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
    end
    consume();
    bus.in_valid = 1'b0;
    check("bp_idle", {63'd0, bus.in_ready}, 64'd1);
    check("bp_acc", bus.acc_data, 64'h0000_0009_0000_0000);
    tick();
    check("bp_no_start", {63'd0, bus.out_valid}, 64'd0);

    run_op("add_mix", OP_ADD, V_1P5, V_M2P0, 64'hFFFF_FFFF_8000_0000, 1'b0);
    run_op("add_min", OP_ADD, Q_MIN, V_M1P0, Q_MIN, 1'b1);
    check("add_acc", bus.acc_data, 64'h0000_0009_0000_0000);

    // asynchronous reset in the middle of a multiply
    issue(OP_MUL, V_1P5, V_2P0);
    repeat (30) tick();
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("mid_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    check("mid_rst_acc", bus.acc_data, 64'd0);
    check("mid_rst_out_data", bus.out_data, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    run_op("mul_one", OP_MUL, Q_ONE, Q_ONE, Q_ONE, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
